// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one full-subtractor cell and a registered borrow
module serial_subtractor #(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh;
    logic [CNT_W-1:0] cnt;
    logic brw, a_msb, b_msb, d, nb, last;
    always_comb begin
        d = a_sh[0] ^ b_sh[0] ^ brw;
        nb = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw);
        last = cnt == CNT_W'(WIDTH - 1);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            brw    <= 1'b0;
            cnt    <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    a_sh   <= a;
                    b_sh   <= b;
                    brw    <= bin;
                    res_sh <= '0;
                    cnt    <= '0;
                    a_msb  <= a[WIDTH-1];
                    b_msb  <= b[WIDTH-1];
                    busy   <= 1'b1;
                    state  <= RUN;
                end
            end else begin
                res_sh <= {d, res_sh[WIDTH-1:1]};
                a_sh   <= a_sh >> 1;
                b_sh   <= b_sh >> 1;
                brw    <= nb;
                cnt    <= cnt + 1'b1;
                // d is the result MSB on the last bit, so overflow is judged from it directly
                if (last) begin
                    diff  <= {d, res_sh[WIDTH-1:1]};
                    bout  <= nb;
                    ovf   <= (a_msb != b_msb) && (d != a_msb);
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            end
        end
    end
endmodule
